// File: rtl/ct_spsram_2048x32_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ct_spsram_2048x32_arb_ctrl
// Brief    : Single-port SRAM sequencer/arbiter. A read requester and a
//            byte-masked write requester share one ct_spsram_2048x32_split
//            port (active-low CEN/GWEN/WEN) using round-robin arbitration.
//            A zero-fill engine clears every word after reset or on flush.
// Options  : CT_SPSRAM_ARB_RDATA_FLOP_EN - register sram_q before returning
//            read data (read latency 2 instead of 1).
// Revision : 1.0 - initial release
// ============================================================================
module ct_spsram_2048x32_arb_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    flush_req,
  output logic                    init_done,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_gnt,
  output logic                    rd_vld,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    wr_gnt,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_WIDTH-1:0]   sram_wen,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  localparam logic GNT_RD = 1'b0;
  localparam logic GNT_WR = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  last_gnt;
  logic [DATA_WIDTH-1:0] wr_wen;

  // State register; reset always lands in the zero-fill sweep
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state <= ST_INIT;
    else           state <= state_nxt;
  end

  // Next state: sweep ends after writing the last word; flush only from IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == LAST_ADDR) state_nxt = ST_IDLE;
      ST_IDLE: if (flush_req)             state_nxt = ST_INIT;
      default:                            state_nxt = ST_INIT;
    endcase
  end

  // Grant logic: lone requester wins, a tie goes to whoever was not granted last
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (state == ST_IDLE) begin
      if (rd_req && wr_req) begin
        rd_gnt = (last_gnt == GNT_WR);
        wr_gnt = (last_gnt == GNT_RD);
      end else begin
        rd_gnt = rd_req;
        wr_gnt = wr_req;
      end
    end
  end

  // Expand active-high byte enables into the active-low per-bit write mask
  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_wen_byte
    assign wr_wen[8*i +: 8] = ~{8{wr_be[i]}};
  end

  // SRAM port drive: zero-fill write in INIT, otherwise the granted access
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt;
    end else if (wr_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = wr_wen;
      sram_a    = wr_addr;
      sram_d    = wr_data;
    end else if (rd_gnt) begin
      sram_cen  = 1'b0;
      sram_a    = rd_addr;
    end
  end

  // Sweep counter, init_done flag and round-robin history
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
      last_gnt  <= GNT_WR;
    end else begin
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      else if (flush_req)   init_cnt <= '0;
      init_done <= (state_nxt == ST_IDLE);
      if (rd_gnt)      last_gnt <= GNT_RD;
      else if (wr_gnt) last_gnt <= GNT_WR;
    end
  end

`ifdef CT_SPSRAM_ARB_RDATA_FLOP_EN
  logic                  rd_pend;
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Two-stage read return: sram_q is flopped before leaving the block
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_pend   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_pend  <= rd_gnt;
      rd_vld_q <= rd_pend;
      if (rd_pend) rd_data_q <= sram_q;
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_data = rd_data_q;
`else
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_hold;

  // One-cycle read return: sram_q passes straight through while valid, held after
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_vld_q <= 1'b0;
      rd_hold  <= '0;
    end else begin
      rd_vld_q <= rd_gnt;
      if (rd_vld_q) rd_hold <= sram_q;
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_data = rd_vld_q ? sram_q : rd_hold;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ct_spsram_2048x32_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_spsram_2048x32_arb_ctrl
// Brief    : Directed self-checking bench for ct_spsram_2048x32_arb_ctrl with
//            a behavioural model of the active-low single-port SRAM macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_spsram_2048x32_arb_ctrl;

`ifdef CT_SPSRAM_ARB_RDATA_FLOP_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic        forever_cpuclk;
  logic        cpurst_b;
  logic        flush_req;
  logic        init_done;
  logic        rd_req;
  logic [10:0] rd_addr;
  logic        rd_gnt;
  logic        rd_vld;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_gnt;
  logic        sram_cen;
  logic        sram_gwen;
  logic [31:0] sram_wen;
  logic [10:0] sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q;

  int vectors;
  int miscompares;

  ct_spsram_2048x32_arb_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
    .forever_cpuclk(forever_cpuclk),
    .cpurst_b      (cpurst_b),
    .flush_req     (flush_req),
    .init_done     (init_done),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_vld        (rd_vld),
    .rd_data       (rd_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_be         (wr_be),
    .wr_gnt        (wr_gnt),
    .sram_cen      (sram_cen),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_a        (sram_a),
    .sram_d        (sram_d),
    .sram_q        (sram_q)
  );

  // Behavioural SRAM: registered Q on read, per-bit active-low write mask
  logic [31:0] mem [2048];
  always @(posedge forever_cpuclk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Walk the zero-fill sweep from 'first' to 'last-1', checking every cycle;
  // a stray flush pulse is injected mid-sweep and must be ignored
  task automatic sweep(input int first, input int last, output int bad);
    bad = 0;
    for (int i = first; i < last; i++) begin
      flush_req = (i == first + 300);
      #1;
      if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0 || sram_cen !== 1'b0 ||
          sram_gwen !== 1'b0 || sram_wen !== 32'h0 || sram_d !== 32'h0 ||
          sram_a !== i[10:0] || init_done !== 1'b0) begin
        if (bad == 0)
          $display("  sweep first bad cycle %0d: a=%0d cen=%b gwen=%b gnt=%b%b done=%b",
                   i, sram_a, sram_cen, sram_gwen, rd_gnt, wr_gnt, init_done);
        bad++;
      end
      @(negedge forever_cpuclk);
    end
    flush_req = 1'b0;
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [31:0] exp_wen);
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    #1;
    vectors++;
    if (wr_gnt !== 1'b1 || sram_gwen !== 1'b0 || sram_cen !== 1'b0 ||
        sram_wen !== exp_wen || sram_a !== a || sram_d !== d) begin
      $display("FAIL write_port: gnt=%b cen=%b gwen=%b wen=%h a=%0d d=%h required gnt=1 cen=0 gwen=0 wen=%h a=%0d d=%h",
               wr_gnt, sram_cen, sram_gwen, sram_wen, sram_a, sram_d, exp_wen, a, d);
      miscompares++;
    end
    @(negedge forever_cpuclk);
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [10:0] a, input logic [31:0] exp);
    rd_req = 1'b1; rd_addr = a;
    #1;
    vectors++;
    if (rd_gnt !== 1'b1 || sram_gwen !== 1'b1 || sram_cen !== 1'b0 ||
        sram_wen !== 32'hFFFF_FFFF || sram_a !== a) begin
      $display("FAIL read_port: gnt=%b cen=%b gwen=%b wen=%h a=%0d required gnt=1 cen=0 gwen=1 wen=ffffffff a=%0d",
               rd_gnt, sram_cen, sram_gwen, sram_wen, sram_a, a);
      miscompares++;
    end
    @(negedge forever_cpuclk);
    rd_req = 1'b0;
    for (int k = 1; k <= RD_LAT; k++) begin
      #1;
      vectors++;
      if (rd_vld !== (k == RD_LAT)) begin
        $display("FAIL read_vld_lat%0d: rd_vld=%b required %b", k, rd_vld, (k == RD_LAT));
        miscompares++;
      end
      if (k == RD_LAT) begin
        vectors++;
        if (rd_data !== exp) begin
          $display("FAIL read_data addr %0d: got %h required %h", a, rd_data, exp);
          miscompares++;
        end
      end
      @(negedge forever_cpuclk);
    end
  endtask

  task automatic test_reset;
    int bad;
    cpurst_b = 1'b0; flush_req = 1'b0;
    rd_req = 1'b1; rd_addr = '0;
    wr_req = 1'b1; wr_addr = '0; wr_data = '0; wr_be = '0;
    repeat (2) @(negedge forever_cpuclk);
    #1;
    vectors++;
    if (init_done !== 1'b0 || rd_vld !== 1'b0 || rd_data !== 32'h0 ||
        rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin
      $display("FAIL reset_state: done=%b vld=%b data=%h gnt=%b%b required 0 0 0 00",
               init_done, rd_vld, rd_data, rd_gnt, wr_gnt);
      miscompares++;
    end
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    sweep(0, 2048, bad);
    vectors++;
    if (bad !== 0) begin
      $display("FAIL init_sweep: %0d bad cycles, required 0", bad);
      miscompares++;
    end
    #1;
    vectors++;
    if (init_done !== 1'b1) begin
      $display("FAIL init_done_after_2048: got %b required 1", init_done);
      miscompares++;
    end
  endtask

  // Both requesters held: first tie after reset goes to read, then alternates
  task automatic test_round_robin;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) #1;
      vectors++;
      if (rd_gnt !== (k % 2 == 0) || wr_gnt !== (k % 2 == 1) || sram_gwen !== (k % 2 == 0)) begin
        $display("FAIL rr_cycle%0d: rd_gnt=%b wr_gnt=%b gwen=%b required %b %b %b",
                 k, rd_gnt, wr_gnt, sram_gwen, (k % 2 == 0), (k % 2 == 1), (k % 2 == 0));
        miscompares++;
      end
      @(negedge forever_cpuclk);
    end
    rd_req = 1'b0; wr_req = 1'b0;
    #1;
    vectors++;
    if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 32'hFFFF_FFFF ||
        sram_a !== 11'd0 || sram_d !== 32'h0 || rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin
      $display("FAIL idle_port: cen=%b gwen=%b wen=%h a=%0d d=%h required 1 1 ffffffff 0 0",
               sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
      miscompares++;
    end
    @(negedge forever_cpuclk);
  endtask

  task automatic test_write_read;
    do_write(11'd5, 32'hA5A5_1234, 4'b0101, 32'hFF00_FF00);
    do_read(11'd5, 32'h00A5_0034);
    #1;
    vectors++;
    if (rd_vld !== 1'b0 || rd_data !== 32'h00A5_0034) begin
      $display("FAIL read_hold: vld=%b data=%h required 0 00a50034", rd_vld, rd_data);
      miscompares++;
    end
    @(negedge forever_cpuclk);
    do_write(11'd6, 32'h1111_2222, 4'b0000, 32'hFFFF_FFFF);
    do_read(11'd6, 32'h0000_0000);
  endtask

  task automatic test_back_to_back;
    do_write(11'd7, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000);
    for (int c = 0; c <= RD_LAT + 1; c++) begin
      rd_req  = (c < 2);
      rd_addr = (c == 0) ? 11'd5 : 11'd7;
      #1;
      if (c < 2) begin
        vectors++;
        if (rd_gnt !== 1'b1) begin
          $display("FAIL b2b_gnt%0d: got %b required 1", c, rd_gnt);
          miscompares++;
        end
      end
      vectors++;
      if (rd_vld !== (c >= RD_LAT)) begin
        $display("FAIL b2b_vld%0d: got %b required %b", c, rd_vld, (c >= RD_LAT));
        miscompares++;
      end
      if (c >= RD_LAT) begin
        vectors++;
        if (rd_data !== ((c == RD_LAT) ? 32'h00A5_0034 : 32'hDEAD_BEEF)) begin
          $display("FAIL b2b_data%0d: got %h required %h", c, rd_data,
                   (c == RD_LAT) ? 32'h00A5_0034 : 32'hDEAD_BEEF);
          miscompares++;
        end
      end
      @(negedge forever_cpuclk);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_flush;
    int bad;
    // write requested in the flush cycle is still granted
    flush_req = 1'b1;
    wr_req = 1'b1; wr_addr = 11'd9; wr_data = 32'h1234_5678; wr_be = 4'hF;
    #1;
    vectors++;
    if (wr_gnt !== 1'b1) begin
      $display("FAIL flush_cycle_gnt: got %b required 1", wr_gnt);
      miscompares++;
    end
    @(negedge forever_cpuclk);
    flush_req = 1'b0; wr_req = 1'b0;
    sweep(0, 2048, bad);
    vectors++;
    if (bad !== 0) begin
      $display("FAIL flush_sweep: %0d bad cycles, required 0", bad);
      miscompares++;
    end
    #1;
    vectors++;
    if (init_done !== 1'b1) begin
      $display("FAIL flush_done: got %b required 1", init_done);
      miscompares++;
    end
    @(negedge forever_cpuclk);
    do_read(11'd7, 32'h0000_0000);
    do_read(11'd9, 32'h0000_0000);
  endtask

  task automatic test_reset_mid_init;
    int bad;
    flush_req = 1'b1;
    @(negedge forever_cpuclk);
    flush_req = 1'b0;
    sweep(0, 1000, bad);
    #1;
    vectors++;
    if (sram_a !== 11'd1000 || bad !== 0) begin
      $display("FAIL pre_reset_cnt: a=%0d bad=%0d required a=1000 bad=0", sram_a, bad);
      miscompares++;
    end
    cpurst_b = 1'b0;
    #1;
    vectors++;
    if (sram_a !== 11'd0 || init_done !== 1'b0 || rd_vld !== 1'b0 || rd_data !== 32'h0) begin
      $display("FAIL mid_init_reset: a=%0d done=%b vld=%b data=%h required 0 0 0 0",
               sram_a, init_done, rd_vld, rd_data);
      miscompares++;
    end
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    sweep(0, 2048, bad);
    vectors++;
    if (bad !== 0) begin
      $display("FAIL restart_sweep: %0d bad cycles, required 0", bad);
      miscompares++;
    end
    #1;
    vectors++;
    if (init_done !== 1'b1) begin
      $display("FAIL restart_done: got %b required 1", init_done);
      miscompares++;
    end
    @(negedge forever_cpuclk);
    // round-robin history was reset, so the next tie goes to read again
    rd_req = 1'b1; rd_addr = 11'd5;
    wr_req = 1'b1; wr_addr = 11'd3; wr_data = 32'h0; wr_be = 4'h0;
    #1;
    vectors++;
    if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0) begin
      $display("FAIL tie_after_reset: rd_gnt=%b wr_gnt=%b required 1 0", rd_gnt, wr_gnt);
      miscompares++;
    end
    @(negedge forever_cpuclk);
    rd_req = 1'b0; wr_req = 1'b0;
    for (int k = 1; k <= RD_LAT; k++) @(negedge forever_cpuclk);
    do_read(11'd5, 32'h0000_0000);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_back_to_back();
    test_flush();
    test_reset_mid_init();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
